// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / multiply-divide stall, branch and jump flush control.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IDEXMemR,
  input  logic [4:0]  IDEXRt,
  input  logic [4:0]  IFIDRs,
  input  logic [4:0]  IFIDRt,
  input  logic        rsR,
  input  logic        rtR,
  input  logic        BranchTaken,
  input  logic        Jump,
  input  logic        MDUStart,
  input  logic        MDUDiv,
  input  logic        MDUReadHiLo,
  output logic        PCWr,
  output logic        IFIDWr,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        MDUBusy,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);

  localparam logic [5:0] MUL_LAT6 = 6'(MUL_LAT);
  localparam logic [5:0] DIV_LAT6 = 6'(DIV_LAT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       load_use, mdu_haz, stall, start_acc;

  assign MDUBusy = (state_q == BUSY);

  always_comb begin
    load_use  = IDEXMemR && (IDEXRt != 5'd0) &&
                (((IDEXRt == IFIDRs) && rsR) || ((IDEXRt == IFIDRt) && rtR));
    mdu_haz   = MDUBusy && (MDUStart || MDUReadHiLo);
    stall     = (load_use || mdu_haz) && !BranchTaken;
    start_acc = MDUStart && !stall && !BranchTaken;
  end

  // A taken branch wins over everything; a stalled jump waits to flush until released.
  always_comb begin
    PCWr      = 1'b1;
    IFIDWr    = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    if (BranchTaken) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (stall) begin
      PCWr      = 1'b0;
      IFIDWr    = 1'b0;
      IDEXFlush = 1'b1;
    end else if (Jump) begin
      IFIDFlush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          cnt_d   = MDUDiv ? DIV_LAT6 : MUL_LAT6;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (IFIDFlush && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = 16'd0;
  assign FlushCnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected outputs are queued when inputs are driven.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rstn;
    logic       memr;
    logic [4:0] idexrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsr;
    logic       rtr;
    logic       bt;
    logic       jmp;
    logic       start;
    logic       div;
    logic       hilo;
  } in_t;

  typedef struct packed {
    logic [3:0]  ctl;   // {PCWr, IFIDWr, IFIDFlush, IDEXFlush}
    logic        busy;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  in_t         cur = '0;
  logic        PCWr, IFIDWr, IFIDFlush, IDEXFlush, MDUBusy;
  logic [15:0] StallCnt, FlushCnt;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_rem = 0;
  int          m_sc  = 0;
  int          m_fc  = 0;
  logic [3:0]  m_ctl;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(cur.rstn), .IDEXMemR(cur.memr), .IDEXRt(cur.idexrt),
    .IFIDRs(cur.rs), .IFIDRt(cur.rt), .rsR(cur.rsr), .rtR(cur.rtr),
    .BranchTaken(cur.bt), .Jump(cur.jmp), .MDUStart(cur.start), .MDUDiv(cur.div),
    .MDUReadHiLo(cur.hilo), .PCWr(PCWr), .IFIDWr(IFIDWr), .IFIDFlush(IFIDFlush),
    .IDEXFlush(IDEXFlush), .MDUBusy(MDUBusy), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  function automatic logic [3:0] exp_ctl(input in_t v, input logic busy);
    logic lu, st;
    lu = v.memr && (v.idexrt != 5'd0) &&
         (((v.idexrt == v.rs) && v.rsr) || ((v.idexrt == v.rt) && v.rtr));
    st = (lu || (busy && (v.start || v.hilo))) && !v.bt;
    if (v.bt) return 4'b1111;
    if (st)   return 4'b0001;
    if (v.jmp) return 4'b1110;
    return 4'b1100;
  endfunction

  assign m_ctl = exp_ctl(cur, m_rem != 0);

  // Reference model: remaining busy cycles plus saturating counters.
  always @(posedge clk) begin
    if (!cur.rstn) begin
      m_rem <= 0;
      m_sc  <= 0;
      m_fc  <= 0;
    end else begin
      if (m_rem != 0) m_rem <= m_rem - 1;
      else if (cur.start && (m_ctl != 4'b0001) && !cur.bt) m_rem <= cur.div ? 32 : 4;
`ifdef HAZARD_PERF_CNT_EN
      if ((m_ctl == 4'b0001) && (m_sc < 65535)) m_sc <= m_sc + 1;
      if (m_ctl[1] && (m_fc < 65535)) m_fc <= m_fc + 1;
`endif
    end
  end

  task automatic apply(input in_t v);
    exp_t e;
    @(negedge clk);
    cur    = v;
    e.ctl  = exp_ctl(v, m_rem != 0);
    e.busy = (m_rem != 0);
    e.sc   = 16'(m_sc);
    e.fc   = 16'(m_fc);
    sb.push_back(e);
  endtask

  function automatic exp_t obs();
    exp_t o;
    o.ctl  = {PCWr, IFIDWr, IFIDFlush, IDEXFlush};
    o.busy = MDUBusy;
    o.sc   = StallCnt;
    o.fc   = FlushCnt;
    return o;
  endfunction

  function automatic in_t idle_in();
    in_t v;
    v = '0;
    v.rstn = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    in_t v;
    exp_t e, o;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin v.memr = 1'b1; v.idexrt = 5'd3; v.rt = 5'd3; v.rtr = 1'b1; end
      apply(v); #1;
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset[%0d] got ctl=%b busy=%b sc=%0d fc=%0d want ctl=%b busy=%b sc=%0d fc=%0d",
                 i, o.ctl, o.busy, o.sc, o.fc, e.ctl, e.busy, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_load_use();
    in_t v;
    exp_t e, o;
    for (int i = 0; i < 7; i++) begin
      v = idle_in();
      v.memr = 1'b1; v.idexrt = 5'd8; v.rs = 5'd8; v.rt = 5'd9; v.rsr = 1'b1;
      case (i)
        1: v.memr = 1'b0;
        2: v.idexrt = 5'd0;
        3: v.rsr = 1'b0;
        4: begin v.rs = 5'd1; v.rt = 5'd8; v.rtr = 1'b1; end
        5: begin v.rs = 5'd1; v.rt = 5'd8; v.rtr = 1'b0; end
        6: v = idle_in();
        default: ;
      endcase
      apply(v); #1;
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL load_use[%0d] got ctl=%b busy=%b want ctl=%b busy=%b",
                 i, o.ctl, o.busy, e.ctl, e.busy);
      end
    end
  endtask

  task automatic test_branch_jump();
    in_t v;
    exp_t e, o;
    for (int i = 0; i < 7; i++) begin
      v = idle_in();
      case (i)
        0: begin v.bt = 1'b1; v.jmp = 1'b1; v.memr = 1'b1; v.idexrt = 5'd4; v.rs = 5'd4; v.rsr = 1'b1; end
        1: begin v.bt = 1'b1; v.start = 1'b1; v.div = 1'b1; end
        2: ;
        3: v.jmp = 1'b1;
        4: begin v.jmp = 1'b1; v.memr = 1'b1; v.idexrt = 5'd4; v.rt = 5'd4; v.rtr = 1'b1; end
        5: v.jmp = 1'b1;
        default: ;
      endcase
      apply(v); #1;
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL branch_jump[%0d] got ctl=%b busy=%b want ctl=%b busy=%b",
                 i, o.ctl, o.busy, e.ctl, e.busy);
      end
    end
  endtask

  task automatic test_mdu();
    in_t v;
    exp_t e, o;
    int busy_n;
    // Divide with mflo waiting in ID throughout.
    busy_n = 0;
    for (int i = 0; i < 34; i++) begin
      v = idle_in();
      if (i == 0) begin v.start = 1'b1; v.div = 1'b1; end
      else v.hilo = 1'b1;
      apply(v); #1;
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (MDUBusy === 1'b1) busy_n++;
      if (o !== e) begin
        n_err++;
        $display("FAIL mdu_div[%0d] got ctl=%b busy=%b want ctl=%b busy=%b",
                 i, o.ctl, o.busy, e.ctl, e.busy);
      end
    end
    n_cmp++;
    if (busy_n !== 32) begin
      n_err++;
      $display("FAIL div_busy_len got %0d want 32", busy_n);
    end
    // Multiply, back-to-back multiply held in ID, branch during busy.
    busy_n = 0;
    for (int i = 0; i < 11; i++) begin
      v = idle_in();
      if (i <= 5) v.start = 1'b1;
      if (i == 7) v.bt = 1'b1;
      apply(v); #1;
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (MDUBusy === 1'b1) busy_n++;
      if (o !== e) begin
        n_err++;
        $display("FAIL mdu_mul[%0d] got ctl=%b busy=%b want ctl=%b busy=%b",
                 i, o.ctl, o.busy, e.ctl, e.busy);
      end
    end
    n_cmp++;
    if (busy_n !== 8) begin
      n_err++;
      $display("FAIL mul_busy_len got %0d want 8", busy_n);
    end
  endtask

  task automatic test_reset_mid();
    in_t v;
    exp_t e, o;
    for (int i = 0; i < 13; i++) begin
      v = idle_in();
      if (i == 0) begin v.start = 1'b1; v.div = 1'b1; end
      if (i == 11) v.rstn = 1'b0;
      apply(v); #1;
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_mid[%0d] got ctl=%b busy=%b sc=%0d fc=%0d want ctl=%b busy=%b sc=%0d fc=%0d",
                 i, o.ctl, o.busy, o.sc, o.fc, e.ctl, e.busy, e.sc, e.fc);
      end
    end
    n_cmp++;
    if ({MDUBusy, StallCnt, FlushCnt} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_mid_clear got busy=%b sc=%0d fc=%0d want 0 0 0", MDUBusy, StallCnt, FlushCnt);
    end
  endtask

  task automatic test_perf();
    in_t v;
    exp_t e, o;
    logic [15:0] want_sc, want_fc;
`ifdef HAZARD_PERF_CNT_EN
    want_sc = 16'd3; want_fc = 16'd2;
`else
    want_sc = 16'd0; want_fc = 16'd0;
`endif
    for (int i = 0; i < 7; i++) begin
      v = idle_in();
      if (i == 0) v.rstn = 1'b0;
      if (i >= 1 && i <= 3) begin v.memr = 1'b1; v.idexrt = 5'd5; v.rs = 5'd5; v.rsr = 1'b1; end
      if (i == 4 || i == 5) v.jmp = 1'b1;
      apply(v); #1;
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL perf[%0d] got ctl=%b sc=%0d fc=%0d want ctl=%b sc=%0d fc=%0d",
                 i, o.ctl, o.sc, o.fc, e.ctl, e.sc, e.fc);
      end
    end
    n_cmp++;
    if (StallCnt !== want_sc || FlushCnt !== want_fc) begin
      n_err++;
      $display("FAIL perf_counts got sc=%0d fc=%0d want sc=%0d fc=%0d", StallCnt, FlushCnt, want_sc, want_fc);
    end
`ifdef HAZARD_PERF_CNT_EN
    v = idle_in();
    v.memr = 1'b1; v.idexrt = 5'd5; v.rs = 5'd5; v.rsr = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      apply(v);
      void'(sb.pop_front());
    end
    apply(idle_in()); #1;
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e || StallCnt !== 16'hFFFF) begin
      n_err++;
      $display("FAIL perf_saturate got sc=%0d want sc=%0d", o.sc, 16'hFFFF);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_jump();
    test_mdu();
    test_reset_mid();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4, multiply busy cycles; legal 1..63.
REQ-002 Parameter DIV_LAT, default 32, divide busy cycles; legal 1..63.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 IDEXMemR  input  1  instruction in EX is a load.
REQ-006 IDEXRt  input  5  load destination register in EX.
REQ-007 IFIDRs, IFIDRt  input  5 each  source registers of instruction in ID.
REQ-008 rsR, rtR  input  1 each  ID instruction actually reads rs / rt.
REQ-009 BranchTaken  input  1  branch resolved taken in EX this cycle.
REQ-010 Jump  input  1  ID instruction is j/jal/jr.
REQ-011 MDUStart  input  1  ID instruction is mult/multu/div/divu.
REQ-012 MDUDiv  input  1  with MDUStart: 1 = divide, 0 = multiply.
REQ-013 MDUReadHiLo  input  1  ID instruction is mfhi/mflo/mthi/mtlo.
REQ-014 PCWr, IFIDWr  output  1 each  PC / IF-ID register write enables.
REQ-015 IFIDFlush, IDEXFlush  output  1 each  insert bubble into IF-ID / ID-EX.
REQ-016 MDUBusy  output  1  multiply/divide unit occupied.
REQ-017 StallCnt, FlushCnt  output  16 each  performance counters.

Function
REQ-018 PCWr, IFIDWr, IFIDFlush, IDEXFlush SHALL be combinational from inputs and registered state; MDUBusy, StallCnt, FlushCnt SHALL be registered.
REQ-019 LoadUse = IDEXMemR && IDEXRt!=0 && ((IDEXRt==IFIDRs && rsR) || (IDEXRt==IFIDRt && rtR)).
REQ-020 MduHaz = MDUBusy && (MDUStart || MDUReadHiLo).
REQ-021 Stall = (LoadUse || MduHaz) && !BranchTaken.
REQ-022 BranchTaken SHALL give PCWr=1, IFIDWr=1, IFIDFlush=1, IDEXFlush=1, overriding Stall and Jump.
REQ-023 Stall SHALL give PCWr=0, IFIDWr=0, IFIDFlush=0, IDEXFlush=1.
REQ-024 Jump && !Stall && !BranchTaken SHALL give IFIDFlush=1, IDEXFlush=0, PCWr=1, IFIDWr=1; a stalled jump SHALL not flush until released.
REQ-025 Otherwise PCWr=1, IFIDWr=1, both flushes 0.
REQ-026 FSM states IDLE, BUSY; 6-bit down-counter Cnt.
REQ-027 Start accepted = MDUStart && !Stall && !BranchTaken; in IDLE it SHALL load Cnt with DIV_LAT if MDUDiv else MUL_LAT and go to BUSY next edge.
REQ-028 In BUSY, Cnt SHALL decrement each cycle; on Cnt==1 the FSM SHALL return to IDLE next edge (MDUBusy high exactly LAT cycles).
REQ-029 MDUBusy SHALL equal (state==BUSY).
REQ-030 A start or HI/LO access in ID on the last BUSY cycle SHALL still stall; it proceeds the cycle MDUBusy falls.
REQ-031 BranchTaken coinciding with MDUStart SHALL squash the start (FSM stays IDLE); BranchTaken during BUSY SHALL NOT abort the operation.

Reset
REQ-032 rst_n low at a clock edge SHALL force IDLE, Cnt=0, MDUBusy=0, StallCnt=0, FlushCnt=0, including mid-operation.
REQ-033 While rst_n is low, PCWr, IFIDWr, IFIDFlush and IDEXFlush SHALL still follow REQ-021..025 from their inputs, with MDUBusy=0.

Configuration
REQ-034 Macro HAZARD_PERF_CNT_EN defined: StallCnt SHALL increment on each Stall cycle, FlushCnt on each cycle with IFIDFlush=1, both saturating at 16'hFFFF.
REQ-035 Macro undefined: StallCnt and FlushCnt ports SHALL remain and be driven constant 0, with no counter registers.

Verification
REQ-036 IDEXMemR=1, IDEXRt=8, IFIDRs=8, rsR=1 for one cycle -> PCWr=0, IFIDWr=0, IDEXFlush=1 that cycle; normal next cycle.
REQ-037 Same with IDEXRt=0, or rsR=0 -> no stall.
REQ-038 MDUStart=1, MDUDiv=1 accepted -> MDUBusy high exactly 32 cycles; mflo in ID during those cycles stalls every cycle and issues the cycle MDUBusy falls.
REQ-039 BranchTaken=1 with LoadUse and Jump both true -> PCWr=1, IFIDFlush=1, IDEXFlush=1; with MDUStart -> MDUBusy stays 0.
REQ-040 rst_n=0 at cycle 10 of a divide -> MDUBusy=0 next cycle; counters 0.
REQ-041 With HAZARD_PERF_CNT_EN, 3 stall cycles and 2 jumps -> StallCnt=3, FlushCnt=2; 70000 stall cycles -> StallCnt=16'hFFFF.
